pss_search_controller: RTL and testbench
========================================

// Module: pss_search_controller
// PURPOSE
//  Sequences PSS detection on top of NUM_NID2=3 parallel PSS correlators (one per N_id_2).
//  Runs a free search until a correlator output crosses threshold, refines the peak over a hold window, then reports it.
//  Tracking mode: only the locked N_id_2 is evaluated, and only in a +/-WINDOW_HALF window around the expected
//  SSB position (period SSB_PERIOD). Loss of lock is declared after MAX_MISS consecutive missed windows.
//  Sits between the correlator bank and the SSS/FFT stage.
// PARAMETERS
//  CORR_DW      24     width of each correlator magnitude (unsigned)
//  CNT_DW       17     width of beat counter / peak position
//  SSB_PERIOD   76800  beats between SSBs (20 ms @ 3.84 Msps); must be > HOLD_LEN + 2*WINDOW_HALF + 2
//  HOLD_LEN     16     beats after the threshold crossing searched for a larger peak
//  WINDOW_HALF  8      half-width of the tracking window, in beats
//  MAX_MISS     3      consecutive missed windows before loss of lock
// PORTS
//  clk_i              in   1          clock
//  reset_ni           in   1          synchronous reset, active low
//  s_axis_corr_tdata  in   3*CORR_DW  {corr2,corr1,corr0}, one beat per input sample
//  s_axis_corr_tvalid in   1          beat valid; no backpressure
//  threshold_i        in   CORR_DW    detection threshold, quasi-static, compared live
//  detect_valid_o     out  1          1-cycle pulse: peak report
//  N_id_2_o           out  2          detected / locked N_id_2 (0..2)
//  peak_pos_o         out  CNT_DW     beat index of the reported peak
//  peak_val_o         out  CORR_DW    magnitude of the reported peak
//  lost_o             out  1          1-cycle pulse: lock lost
//  window_o           out  1          high while state is TRACK_WIN
//  state_o            out  2          0 SEARCH, 1 HOLD, 2 TRACK_WAIT, 3 TRACK_WIN
// BEHAVIOUR
//  - Reset (reset_ni=0 at a clock edge):
//    - All outputs are 0; state is SEARCH; beat counter, miss counter and best registers are 0.
//    - A reset mid-operation aborts any HOLD or window; no pulse is produced.
//  - Beats:
//    - A beat is a cycle with s_axis_corr_tvalid=1. Beat index starts at 0 after reset and increments per beat.
//    - The beat index wraps modulo 2^CNT_DW; all position arithmetic is modulo 2^CNT_DW.
//    - With tvalid=0, the FSM and all counters hold.
//  - Compare rules:
//    - Threshold test is strict: corr > threshold_i.
//    - Best-peak update is strict (>), so the earliest beat wins.
//    - Within one beat, the maximum of the three values wins; on a tie the lowest N_id_2 wins.
//  - SEARCH:
//    - On a beat where any corr_k > threshold, capture best (val, k, pos=beat index) and go to HOLD.
//  - HOLD:
//    - Consumes exactly HOLD_LEN further beats, updating best over all 3 correlators.
//    - On the edge consuming the last of these beats, register detect_valid_o=1 with N_id_2_o, peak_pos_o and
//      peak_val_o from best; set P=best.pos and go to TRACK_WAIT.
//  - TRACK_WAIT:
//    - Enter TRACK_WIN on the edge consuming beat P+SSB_PERIOD-WINDOW_HALF-1.
//  - TRACK_WIN:
//    - Covers beats P+SSB_PERIOD-WINDOW_HALF .. P+SSB_PERIOD+WINDOW_HALF inclusive (2*WINDOW_HALF+1 beats).
//    - Only corr[N_id_2_o] is evaluated; best is cleared to 0 at window entry.
//    - On the edge consuming the last window beat:
//      - best > threshold: detect_valid_o pulse (N_id_2 unchanged), P=best.pos, miss=0, go to TRACK_WAIT.
//      - else, miss<MAX_MISS-1: miss++, P=P+SSB_PERIOD (flywheel), go to TRACK_WAIT, no pulse.
//      - else (miss=MAX_MISS-1): lost_o pulse, miss=0, go to SEARCH. N_id_2_o holds its last value;
//        peak outputs are not cleared.
//  - Pulses:
//    - detect_valid_o and lost_o are high for exactly one clock, then 0.
//    - Report outputs hold their values between reports.
//  - Latency: reports are registered and visible in the cycle after the clock edge that consumes the last
//    HOLD or window beat.
// TESTING
//  - Reset: hold reset_ni=0 for 3 cycles with random tvalid/data -> all outputs 0, state_o=0. Release -> first
//    beat has index 0.
//  - Single peak: threshold=1000; corr1=5000 at beat 100, corr1=3000 at beat 101, all else 0 -> detect pulse
//    after beat 116 with N_id_2=1, pos=100, val=5000; state_o=2.
//  - Refinement and tie: corr0=corr2=4000 at beat 50, corr2=4500 at beat 60 -> N_id_2=2, pos=60, val=4500.
//    With only the tie at beat 50 -> N_id_2=0.
//  - Tracking (SSB_PERIOD=200, WINDOW_HALF=4):
//    - Lock at beat 100, then corr=6000 at beat 302 -> window_o high for beats 296..304; pulse after beat 304
//      with pos=302.
//    - Next window is 498..506.
//    - corr of another N_id_2 in the window is ignored.
//  - Loss of lock (SSB_PERIOD=200, MAX_MISS=3): lock at beat 100, then all zeros -> no pulses at windows
//    296..304 and 496..504; lost_o pulse after beat 704; state_o=0.
//  - Gaps and abort: random tvalid gaps (50%) in the single-peak case give the same pos/val results.
//    reset_ni=0 during HOLD -> no detect pulse, state_o=0.

Source files
------------

// File: rtl/pss_search_controller.sv
// -----------------------------------------------------------------------------
// pss_search_controller
//
// Sequences PSS detection on top of three parallel PSS correlators (one per
// N_id_2). A free search runs until any correlator magnitude crosses the
// threshold. The peak is then refined over a hold window of HOLD_LEN beats and
// reported. After that the block tracks the locked N_id_2 only, inside a
// +/-WINDOW_HALF beat window around the expected SSB position, one SSB_PERIOD
// after the last accepted peak. MAX_MISS consecutive empty windows declare
// loss of lock and the block falls back to the free search.
//
// Ports
//   clk_i              clock
//   reset_ni           synchronous reset, active low
//   s_axis_corr_tdata  {corr2, corr1, corr0}, unsigned magnitudes, one per beat
//   s_axis_corr_tvalid beat valid
//   threshold_i        detection threshold, compared live (strictly greater)
//   detect_valid_o     1-cycle pulse: peak report
//   N_id_2_o           detected / locked N_id_2 (0..2)
//   peak_pos_o         beat index of the reported peak
//   peak_val_o         magnitude of the reported peak
//   lost_o             1-cycle pulse: lock lost
//   window_o           high while the tracking window is open
//   state_o            FSM state: 0 SEARCH, 1 HOLD, 2 TRACK_WAIT, 3 TRACK_WIN
//
// Handshake: the correlator stream is valid-only. A beat is any cycle with
// s_axis_corr_tvalid=1; there is no ready, so every valid beat is consumed on
// the clock edge where it is presented. Cycles without tvalid freeze the FSM
// and every counter; only the one-cycle pulses fall back to 0.
// -----------------------------------------------------------------------------
module pss_search_controller #(
    parameter int CORR_DW     = 24,
    parameter int CNT_DW      = 17,
    parameter int SSB_PERIOD  = 76800,
    parameter int HOLD_LEN    = 16,
    parameter int WINDOW_HALF = 8,
    parameter int MAX_MISS    = 3
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic [3*CORR_DW-1:0]   s_axis_corr_tdata,
    input  logic                   s_axis_corr_tvalid,
    input  logic [CORR_DW-1:0]     threshold_i,
    output logic                   detect_valid_o,
    output logic [1:0]             N_id_2_o,
    output logic [CNT_DW-1:0]      peak_pos_o,
    output logic [CORR_DW-1:0]     peak_val_o,
    output logic                   lost_o,
    output logic                   window_o,
    output logic [1:0]             state_o
);

    typedef enum logic [1:0] {
        ST_SEARCH     = 2'd0,
        ST_HOLD       = 2'd1,
        ST_TRACK_WAIT = 2'd2,
        ST_TRACK_WIN  = 2'd3
    } state_e;

    localparam int HOLD_W = (HOLD_LEN > 1) ? $clog2(HOLD_LEN) : 1;
    localparam int MISS_W = (MAX_MISS > 1) ? $clog2(MAX_MISS) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LEN - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MAX_MISS - 1);

    // Offsets from the anchor P, all taken modulo 2^CNT_DW.
    localparam logic [CNT_DW-1:0] PERIOD_OFS  = CNT_DW'(SSB_PERIOD);
    localparam logic [CNT_DW-1:0] WAIT_OFS    = CNT_DW'(SSB_PERIOD - WINDOW_HALF - 1);
    localparam logic [CNT_DW-1:0] WIN_END_OFS = CNT_DW'(SSB_PERIOD + WINDOW_HALF);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e              state_q,    state_d;
    logic [CNT_DW-1:0]   beat_q,     beat_d;      // index of the next beat
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [MISS_W-1:0]   miss_q,     miss_d;
    logic [CNT_DW-1:0]   anchor_q,   anchor_d;    // P: position of the last peak
    logic [CORR_DW-1:0]  best_val_q, best_val_d;
    logic [1:0]          best_nid_q, best_nid_d;
    logic [CNT_DW-1:0]   best_pos_q, best_pos_d;
    logic                detect_q,   detect_d;
    logic                lost_q,     lost_d;
    logic [1:0]          nid_q,      nid_d;
    logic [CNT_DW-1:0]   pos_q,      pos_d;
    logic [CORR_DW-1:0]  val_q,      val_d;

    // ------------------------------------------------------------------
    // Per-beat datapath
    // ------------------------------------------------------------------
    logic [CORR_DW-1:0] corr0, corr1, corr2;
    logic [CORR_DW-1:0] beat_max_val;
    logic [1:0]         beat_max_nid;
    logic [CORR_DW-1:0] locked_corr;
    logic [CNT_DW-1:0]  wait_target;
    logic [CNT_DW-1:0]  win_end_target;

    assign corr0 = s_axis_corr_tdata[0*CORR_DW +: CORR_DW];
    assign corr1 = s_axis_corr_tdata[1*CORR_DW +: CORR_DW];
    assign corr2 = s_axis_corr_tdata[2*CORR_DW +: CORR_DW];

    // Strict comparisons in ascending N_id_2 order: a tie keeps the lower index.
    always_comb begin
        beat_max_val = corr0;
        beat_max_nid = 2'd0;
        if (corr1 > beat_max_val) begin
            beat_max_val = corr1;
            beat_max_nid = 2'd1;
        end
        if (corr2 > beat_max_val) begin
            beat_max_val = corr2;
            beat_max_nid = 2'd2;
        end
    end

    // While tracking only the correlator of the locked N_id_2 is considered.
    always_comb begin
        case (nid_q)
            2'd0:    locked_corr = corr0;
            2'd1:    locked_corr = corr1;
            default: locked_corr = corr2;
        endcase
    end

    assign wait_target    = anchor_q + WAIT_OFS;
    assign win_end_target = anchor_q + WIN_END_OFS;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        hold_cnt_d = hold_cnt_q;
        miss_d     = miss_q;
        anchor_d   = anchor_q;
        best_val_d = best_val_q;
        best_nid_d = best_nid_q;
        best_pos_d = best_pos_q;
        nid_d      = nid_q;
        pos_d      = pos_q;
        val_d      = val_q;
        detect_d   = 1'b0;
        lost_d     = 1'b0;

        if (s_axis_corr_tvalid) begin
            beat_d = beat_q + 1'b1;

            case (state_q)
                ST_SEARCH: begin
                    if (beat_max_val > threshold_i) begin
                        best_val_d = beat_max_val;
                        best_nid_d = beat_max_nid;
                        best_pos_d = beat_q;
                        hold_cnt_d = '0;
                        state_d    = ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    if (beat_max_val > best_val_q) begin
                        best_val_d = beat_max_val;
                        best_nid_d = beat_max_nid;
                        best_pos_d = beat_q;
                    end
                    // The last hold beat still takes part in refinement, so
                    // the report uses the already-updated best.
                    if (hold_cnt_q == HOLD_LAST) begin
                        detect_d = 1'b1;
                        nid_d    = best_nid_d;
                        pos_d    = best_pos_d;
                        val_d    = best_val_d;
                        anchor_d = best_pos_d;
                        miss_d   = '0;
                        state_d  = ST_TRACK_WAIT;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end

                ST_TRACK_WAIT: begin
                    if (beat_q == wait_target) begin
                        best_val_d = '0;
                        best_nid_d = '0;
                        best_pos_d = '0;
                        state_d    = ST_TRACK_WIN;
                    end
                end

                ST_TRACK_WIN: begin
                    if (locked_corr > best_val_q) begin
                        best_val_d = locked_corr;
                        best_pos_d = beat_q;
                    end
                    if (beat_q == win_end_target) begin
                        if (best_val_d > threshold_i) begin
                            detect_d = 1'b1;
                            pos_d    = best_pos_d;
                            val_d    = best_val_d;
                            anchor_d = best_pos_d;
                            miss_d   = '0;
                            state_d  = ST_TRACK_WAIT;
                        end else if (miss_q == MISS_LAST) begin
                            // N_id_2 and peak outputs intentionally keep
                            // their last reported values.
                            lost_d  = 1'b1;
                            miss_d  = '0;
                            state_d = ST_SEARCH;
                        end else begin
                            // Flywheel: advance the anchor one period as if
                            // the SSB had been seen exactly where expected.
                            miss_d   = miss_q + 1'b1;
                            anchor_d = anchor_q + PERIOD_OFS;
                            state_d  = ST_TRACK_WAIT;
                        end
                    end
                end

                default: state_d = ST_SEARCH;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= ST_SEARCH;
            beat_q     <= '0;
            hold_cnt_q <= '0;
            miss_q     <= '0;
            anchor_q   <= '0;
            best_val_q <= '0;
            best_nid_q <= '0;
            best_pos_q <= '0;
            detect_q   <= 1'b0;
            lost_q     <= 1'b0;
            nid_q      <= '0;
            pos_q      <= '0;
            val_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            hold_cnt_q <= hold_cnt_d;
            miss_q     <= miss_d;
            anchor_q   <= anchor_d;
            best_val_q <= best_val_d;
            best_nid_q <= best_nid_d;
            best_pos_q <= best_pos_d;
            detect_q   <= detect_d;
            lost_q     <= lost_d;
            nid_q      <= nid_d;
            pos_q      <= pos_d;
            val_q      <= val_d;
        end
    end

    assign detect_valid_o = detect_q;
    assign lost_o         = lost_q;
    assign N_id_2_o       = nid_q;
    assign peak_pos_o     = pos_q;
    assign peak_val_o     = val_q;
    assign window_o       = (state_q == ST_TRACK_WIN);
    assign state_o        = state_q;

endmodule

// File: tb/tb_pss_search_controller.sv
// -----------------------------------------------------------------------------
// Testbench for pss_search_controller (SSB_PERIOD=200, WINDOW_HALF=4,
// HOLD_LEN=16, MAX_MISS=3). Reports and loss pulses are checked through an
// expected-report queue; the tracking window is checked on every cycle against
// the window ranges expected for the running sequence.
// -----------------------------------------------------------------------------
module tb_pss_search_controller;

    localparam int CORR_DW  = 24;
    localparam int CNT_DW   = 17;
    localparam int HOLD_LEN = 16;
    localparam int W        = 62;  // {kind[2], at[17], nid[2], pos[17], val[24]}

    // ---------------- clock / reset / DUT ----------------
    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [3*CORR_DW-1:0] s_axis_corr_tdata;
    logic                 s_axis_corr_tvalid;
    logic [CORR_DW-1:0]   threshold;
    logic                 detect_valid_o;
    logic [1:0]           N_id_2_o;
    logic [CNT_DW-1:0]    peak_pos_o;
    logic [CORR_DW-1:0]   peak_val_o;
    logic                 lost_o;
    logic                 window_o;
    logic [1:0]           state_o;

    always #5 clk = ~clk;

    pss_search_controller #(
        .CORR_DW    (CORR_DW),
        .CNT_DW     (CNT_DW),
        .SSB_PERIOD (200),
        .HOLD_LEN   (HOLD_LEN),
        .WINDOW_HALF(4),
        .MAX_MISS   (3)
    ) dut (
        .clk_i             (clk),
        .reset_ni          (reset_n),
        .s_axis_corr_tdata (s_axis_corr_tdata),
        .s_axis_corr_tvalid(s_axis_corr_tvalid),
        .threshold_i       (threshold),
        .detect_valid_o    (detect_valid_o),
        .N_id_2_o          (N_id_2_o),
        .peak_pos_o        (peak_pos_o),
        .peak_val_o        (peak_val_o),
        .lost_o            (lost_o),
        .window_o          (window_o),
        .state_o           (state_o)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cur_beat = 0;   // index of the next beat to be consumed
    int           last_beat = 0;  // index of the most recently consumed beat

    // Stimulus events for the running sequence and expected window ranges.
    int           ev_beat[$];
    logic [71:0]  ev_data[$];
    int           win_lo[$];
    int           win_hi[$];

    typedef struct {
        logic [23:0] thr;
        int          b1;
        logic [23:0] a0, a1, a2;
        int          b2;
        logic [23:0] d0, d1, d2;
        int          trig;
        logic [1:0]  nid;
        int          pos;
        logic [23:0] val;
        int          gap_pct;
    } vec_t;

    vec_t vecs[11];

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [1:0] kind, input int at, input logic [1:0] nid,
                            input int pos, input logic [23:0] val);
        exp_q.push_back({kind, 17'(at), nid, 17'(pos), val});
    endtask

    function automatic logic [71:0] data_for(input int beat);
        logic [71:0] d;
        d = '0;
        foreach (ev_beat[j]) if (ev_beat[j] == beat) d = ev_data[j];
        return d;
    endfunction

    function automatic logic [71:0] rand_data();
        return 72'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic add_event(input int beat, input logic [23:0] c0, input logic [23:0] c1,
                             input logic [23:0] c2);
        ev_beat.push_back(beat);
        ev_data.push_back({c2, c1, c0});
    endtask

    task automatic clear_seq();
        ev_beat.delete();
        ev_data.delete();
        win_lo.delete();
        win_hi.delete();
        exp_q.delete();
    endtask

    // Output monitor, evaluated on the falling edge after every clock.
    task automatic sample();
        logic [W-1:0] act;
        logic [W-1:0] e;
        logic         exp_win;
        if (detect_valid_o || lost_o) begin
            act = {lost_o, detect_valid_o, 17'(last_beat), N_id_2_o, peak_pos_o, peak_val_o};
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got 0x%0h, expected no pulse (t=%0t)", act, $time);
            end else begin
                e = exp_q.pop_front();
                check("report", 64'(act), 64'(e));
            end
        end
        exp_win = 1'b0;
        foreach (win_lo[j]) if (cur_beat >= win_lo[j] && cur_beat <= win_hi[j]) exp_win = 1'b1;
        check("window_o", 64'(window_o), 64'(exp_win));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic v, input logic [71:0] d);
        s_axis_corr_tvalid = v;
        s_axis_corr_tdata  = d;
        @(posedge clk);
        if (!reset_n) begin
            cur_beat = 0;
        end else if (v) begin
            last_beat = cur_beat;
            cur_beat++;
        end
        @(negedge clk);
        sample();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) step(1'($urandom_range(0, 1)), rand_data());
        check("rst_detect", 64'(detect_valid_o), 64'd0);
        check("rst_nid",    64'(N_id_2_o),       64'd0);
        check("rst_pos",    64'(peak_pos_o),     64'd0);
        check("rst_val",    64'(peak_val_o),     64'd0);
        check("rst_lost",   64'(lost_o),         64'd0);
        check("rst_window", 64'(window_o),       64'd0);
        check("rst_state",  64'(state_o),        64'd0);
        reset_n = 1'b1;
    endtask

    task automatic run_beats(input int n, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(1, 100) <= gap_pct) step(1'b0, rand_data());
            step(1'b1, data_for(i));
        end
    endtask

    // ---------------- test ----------------
    initial begin
        reset_n            = 1'b0;
        s_axis_corr_tvalid = 1'b0;
        s_axis_corr_tdata  = '0;
        threshold          = 24'd1000;

        //           thr    b1   a0    a1    a2    b2   d0    d1    d2   trig nid pos  val   gap
        vecs[0]  = '{24'd1000, 100, 24'd0, 24'd5000, 24'd0, 101, 24'd0, 24'd3000, 24'd0, 100, 2'd1, 100, 24'd5000, 0};
        vecs[1]  = '{24'd1000, 50, 24'd4000, 24'd0, 24'd4000, 60, 24'd0, 24'd0, 24'd4500, 50, 2'd2, 60, 24'd4500, 0};
        vecs[2]  = '{24'd1000, 50, 24'd4000, 24'd0, 24'd4000, -1, 24'd0, 24'd0, 24'd0, 50, 2'd0, 50, 24'd4000, 0};
        vecs[3]  = '{24'd1000, 30, 24'd1000, 24'd0, 24'd0, 40, 24'd0, 24'd1001, 24'd0, 40, 2'd1, 40, 24'd1001, 0};
        vecs[4]  = '{24'd1000, 20, 24'd0, 24'd0, 24'd3000, 25, 24'd3000, 24'd0, 24'd0, 20, 2'd2, 20, 24'd3000, 0};
        vecs[5]  = '{24'd1000, 10, 24'd0, 24'd2000, 24'd0, 26, 24'd2500, 24'd0, 24'd0, 10, 2'd0, 26, 24'd2500, 0};
        vecs[6]  = '{24'd1000, 10, 24'd0, 24'd2000, 24'd0, 27, 24'd9000, 24'd0, 24'd0, 10, 2'd1, 10, 24'd2000, 0};
        vecs[7]  = '{24'd1000, 5, 24'd7000, 24'd7000, 24'd7000, -1, 24'd0, 24'd0, 24'd0, 5, 2'd0, 5, 24'd7000, 0};
        vecs[8]  = '{24'd10, 0, 24'd0, 24'd0, 24'd500, -1, 24'd0, 24'd0, 24'd0, 0, 2'd2, 0, 24'd500, 0};
        vecs[9]  = '{24'd1000, 5, 24'd2000, 24'd3000, 24'd0, -1, 24'd0, 24'd0, 24'd0, 5, 2'd1, 5, 24'd3000, 0};
        vecs[10] = '{24'd1000, 100, 24'd0, 24'd5000, 24'd0, 101, 24'd0, 24'd3000, 24'd0, 100, 2'd1, 100, 24'd5000, 50};

        // Search / hold vectors
        foreach (vecs[i]) begin
            clear_seq();
            add_event(vecs[i].b1, vecs[i].a0, vecs[i].a1, vecs[i].a2);
            if (vecs[i].b2 >= 0) add_event(vecs[i].b2, vecs[i].d0, vecs[i].d1, vecs[i].d2);
            threshold = vecs[i].thr;
            push_exp(2'b01, vecs[i].trig + HOLD_LEN, vecs[i].nid, vecs[i].pos, vecs[i].val);
            do_reset();
            run_beats(vecs[i].trig + HOLD_LEN + 12, vecs[i].gap_pct);
            check($sformatf("vec%0d_drained", i), 64'(exp_q.size()), 64'd0);
            check($sformatf("vec%0d_state", i),   64'(state_o),      64'd2);
            check($sformatf("vec%0d_nid", i),     64'(N_id_2_o),     64'(vecs[i].nid));
            check($sformatf("vec%0d_pos", i),     64'(peak_pos_o),   64'(vecs[i].pos));
            check($sformatf("vec%0d_val", i),     64'(peak_val_o),   64'(vecs[i].val));
        end

        // Tracking: lock at 100, window hits, foreign N_id_2 and out-of-window ignored
        clear_seq();
        threshold = 24'd1000;
        add_event(100, 24'd0, 24'd5000, 24'd0);
        add_event(300, 24'd9000, 24'd0, 24'd0);
        add_event(302, 24'd0, 24'd6000, 24'd0);
        add_event(497, 24'd0, 24'd9000, 24'd0);
        add_event(506, 24'd0, 24'd1500, 24'd0);
        win_lo.push_back(296); win_hi.push_back(304);
        win_lo.push_back(498); win_hi.push_back(506);
        push_exp(2'b01, 116, 2'd1, 100, 24'd5000);
        push_exp(2'b01, 304, 2'd1, 302, 24'd6000);
        push_exp(2'b01, 506, 2'd1, 506, 24'd1500);
        do_reset();
        run_beats(520, 0);
        check("track_drained", 64'(exp_q.size()), 64'd0);
        check("track_state",   64'(state_o),      64'd2);

        // Loss of lock: three empty windows, flywheel anchors 300 and 500
        clear_seq();
        add_event(100, 24'd0, 24'd5000, 24'd0);
        win_lo.push_back(296); win_hi.push_back(304);
        win_lo.push_back(496); win_hi.push_back(504);
        win_lo.push_back(696); win_hi.push_back(704);
        push_exp(2'b01, 116, 2'd1, 100, 24'd5000);
        push_exp(2'b10, 704, 2'd1, 100, 24'd5000);
        do_reset();
        run_beats(712, 0);
        check("loss_drained", 64'(exp_q.size()), 64'd0);
        check("loss_state",   64'(state_o),      64'd0);

        // Abort: reset in the middle of HOLD produces no report
        clear_seq();
        add_event(100, 24'd0, 24'd5000, 24'd0);
        do_reset();
        run_beats(110, 0);
        check("abort_in_hold", 64'(state_o), 64'd1);
        do_reset();
        ev_beat.delete();
        ev_data.delete();
        run_beats(60, 0);
        check("abort_state",   64'(state_o),      64'd0);
        check("abort_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
